rfg_axis_protocol_master: RTL
=============================

Name: rfg_axis_protocol_master

Overview:
- Initiator side of the RFG byte protocol: turns a register-access command into a header/address/length/data byte stream on an AXIS master.
- Collects the read-back byte stream from the RFG responder on an AXIS slave and hands it to the user.
- Sits on the firmware side, where on-chip sequencers need register access over the AXIS interconnect without going through software I/O.

Parameters:
- DATA_WIDTH, 8, AXIS data width; only 8 is supported.
- ID_WIDTH, 8, width of m_axis_tid and s_axis_tid.
- SOURCE_ID, 0, value driven on m_axis_tid; the responder uses it to route answers back to this port.
- TIMEOUT_CYCLES, 4096, read-response timeout; used only with the optional feature.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_incr  in  1  address auto-increment flag
- cmd_vchannel  in  4  virtual channel for the header
- cmd_address  in  8  register address
- cmd_length  in  16  byte count; 0 is illegal
- wr_tdata  in  8  write payload byte
- wr_tvalid  in  1  payload valid
- wr_tready  out  1  payload accepted
- m_axis_tdata  out  8  protocol byte
- m_axis_tvalid  out  1  byte valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last byte of frame
- m_axis_tid  out  ID_WIDTH  constant SOURCE_ID
- s_axis_tdata  in  8  read-back byte
- s_axis_tvalid  in  1  read-back valid
- s_axis_tready  out  1  read-back accepted
- s_axis_tlast  in  1  responder last flag
- rd_tdata  out  8  read byte to user
- rd_tvalid  out  1  read byte valid
- rd_tready  in  1  user ready
- rd_tlast  out  1  final read byte
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of command
- error  out  1  one-cycle pulse on a protocol fault

Behaviour:
- Reset values: state IDLE; cmd_ready=1, m_axis_tvalid=0, m_axis_tlast=0, wr_tready=0, s_axis_tready=1 (IDLE drain), done=0, error=0, busy=0, counters 0.
- Header byte: {vchannel[3:0], 1'b0, incr, read=!write, write}. Frame byte order: header, address, length[7:0], length[15:8], then payload (write only).
- States: IDLE -> HDR -> ADDR -> LENA -> LENB -> (WRITE_DATA | READ_DATA) -> IDLE.
- IDLE: cmd_ready=1. On acceptance, latch all cmd fields; remaining=cmd_length.
  - If cmd_length==0: stay IDLE, pulse error the next cycle, emit nothing.
  - Otherwise go to HDR; the header is presented with m_axis_tvalid=1 on the next cycle (latency 1).
- Master handshake:
  - m_axis_tdata/tvalid/tlast are registered.
  - A byte is held stable until m_axis_tready; the next byte is loaded in the same cycle as the accepting handshake, giving 1 byte/cycle with tready high.
  - tvalid never drops without a handshake, except on reset.
- LENB: tlast=1 on this byte if read. Once accepted, go to READ_DATA (read) or WRITE_DATA (write).
- WRITE_DATA:
  - wr_tready = !m_axis_tvalid || m_axis_tready.
  - Each accepted wr byte goes to m_axis_tdata and decrements remaining. tlast=1 when remaining==1.
  - After the last byte's m_axis handshake: pulse done, return to IDLE.
  - wr_tready=0 in all other states.
- READ_DATA: combinational pass-through.
  - rd_tdata=s_axis_tdata, rd_tvalid=s_axis_tvalid, s_axis_tready=rd_tready.
  - rd_tlast=(remaining==1).
  - Each s_axis handshake decrements remaining. At remaining==1 with a handshake: pulse done, return to IDLE.
  - Mismatch: if s_axis_tlast != (remaining==1) on any handshake, pulse error. The byte is still forwarded and counting continues.
- IDLE and the header states: s_axis_tready=1 and stray bytes are discarded; each stray byte pulses error. rd_tvalid=0 outside READ_DATA.
- Counter arithmetic: remaining is 16-bit, never decremented below 1. Length 65535 is legal; no wrap.
- Simultaneous events: a cmd_valid that arrives while busy is held off (cmd_ready=0); a new command is accepted no earlier than the cycle after done.
- Reset mid-operation: return to IDLE next edge, drop m_axis_tvalid, discard latched command, no done/error pulse.

Optional Feature:
- Macro RFG_AXIS_PROTOCOL_MASTER_TIMEOUT_EN.
- Defined:
  - In READ_DATA, a cycle counter clears on every s_axis handshake and increments otherwise.
  - On reaching TIMEOUT_CYCLES: pulse error, abort to IDLE without done; late bytes are then drained as stray.
- Undefined: no counter; READ_DATA waits indefinitely.

Test Plan:
- Write, vchannel 3, incr=1, addr 0x10, len 2, data 0xAA,0xBB, m_axis_tready=1 -> m_axis bytes 0x35,0x10,0x02,0x00,0xAA,0xBB, tlast only on 0xBB, done one cycle after the 0xBB handshake.
- Read, vchannel 1, incr=0, addr 0x20, len 3; responder returns 0x01,0x02,0x03 with tlast on 0x03 -> m_axis 0x12,0x20,0x03,0x00 (tlast on 0x00); rd_* shows 0x01..0x03, rd_tlast on 0x03, done, no error.
- Backpressure: m_axis_tready toggling 1010 during a len-4 write -> every byte held stable until accepted, no loss or duplication; rd_tready=0 for 5 cycles mid-read -> s_axis_tready=0, no bytes dropped.
- cmd_length=0 -> error pulse one cycle later, no m_axis_tvalid, busy stays 0; a stray s_axis byte in IDLE -> accepted and error pulsed.
- Responder sets tlast on byte 2 of a len-3 read -> error pulse on byte 2, byte 3 still forwarded, done after byte 3.
- Timeout enabled with TIMEOUT_CYCLES=16, read len 1 with no response -> error at cycle 16 of READ_DATA, back to IDLE; areset asserted mid-write -> idle outputs on the next edge.

Source files
------------

// File: rtl/rfg_axis_protocol_master.sv
// RFG byte-protocol initiator: serialises a register command onto an AXIS master and
// forwards the responder's read-back stream. Optional read timeout: RFG_AXIS_PROTOCOL_MASTER_TIMEOUT_EN.
module rfg_axis_protocol_master #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned SOURCE_ID      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_incr,
    input  logic [3:0]            cmd_vchannel,
    input  logic [7:0]            cmd_address,
    input  logic [15:0]           cmd_length,
    input  logic [DATA_WIDTH-1:0] wr_tdata,
    input  logic                  wr_tvalid,
    output logic                  wr_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] rd_tdata,
    output logic                  rd_tvalid,
    input  logic                  rd_tready,
    output logic                  rd_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        StIdle, StHdr, StAddr, StLena, StLenb, StWrite, StRead
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic                    m_tlast_q, m_tlast_d;
    logic [15:0]             remaining_q, remaining_d;
    logic                    write_q, write_d;
    logic [7:0]              addr_q, addr_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    m_hs;
    logic                    s_hs;

`ifdef RFG_AXIS_PROTOCOL_MASTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tid    = ID_WIDTH'(SOURCE_ID);
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign error         = error_q;
    assign rd_tdata      = s_axis_tdata;

    always_comb begin
        state_d     = state_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        remaining_d = remaining_q;
        write_d     = write_q;
        addr_d      = addr_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        m_hs        = m_tvalid_q && m_axis_tready;
        // Hold off a new command during the done pulse so it lands strictly after completion.
        cmd_ready     = (state_q == StIdle) && !done_q;
        wr_tready     = 1'b0;
        s_axis_tready = 1'b1;
        rd_tvalid     = 1'b0;
        rd_tlast      = 1'b0;
        s_hs          = 1'b0;
`ifdef RFG_AXIS_PROTOCOL_MASTER_TIMEOUT_EN
        to_cnt_d = '0;
`endif

        // Outside a read, responder bytes are drained and flagged as stray.
        if (state_q != StRead && s_axis_tvalid) begin
            error_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    write_d     = cmd_write;
                    addr_d      = cmd_address;
                    remaining_d = cmd_length;
                    if (cmd_length == 16'd0) begin
                        error_d = 1'b1;
                    end else begin
                        state_d    = StHdr;
                        m_tvalid_d = 1'b1;
                        m_tlast_d  = 1'b0;
                        m_tdata_d  = {cmd_vchannel, 1'b0, cmd_incr, !cmd_write, cmd_write};
                    end
                end
            end
            StHdr: begin
                if (m_hs) begin
                    m_tdata_d = addr_q;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (m_hs) begin
                    m_tdata_d = remaining_q[7:0];
                    state_d   = StLena;
                end
            end
            StLena: begin
                if (m_hs) begin
                    m_tdata_d = remaining_q[15:8];
                    m_tlast_d = !write_q;
                    state_d   = StLenb;
                end
            end
            StLenb: begin
                if (m_hs) begin
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                    state_d    = write_q ? StWrite : StRead;
                end
            end
            StWrite: begin
                // Once the final byte is loaded, stop pulling payload until it drains.
                wr_tready = !m_tlast_q && (!m_tvalid_q || m_axis_tready);
                if (wr_tvalid && wr_tready) begin
                    m_tdata_d  = wr_tdata;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = (remaining_q == 16'd1);
                    if (remaining_q > 16'd1) begin
                        remaining_d = remaining_q - 16'd1;
                    end
                end else if (m_hs) begin
                    m_tvalid_d = 1'b0;
                end
                if (m_hs && m_tlast_q) begin
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
            StRead: begin
                s_axis_tready = rd_tready;
                rd_tvalid     = s_axis_tvalid;
                rd_tlast      = (remaining_q == 16'd1);
                s_hs          = s_axis_tvalid && rd_tready;
                if (s_hs) begin
                    if (s_axis_tlast != (remaining_q == 16'd1)) begin
                        error_d = 1'b1;
                    end
                    if (remaining_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        remaining_d = remaining_q - 16'd1;
                    end
                end
`ifdef RFG_AXIS_PROTOCOL_MASTER_TIMEOUT_EN
                if (!s_hs) begin
                    if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= StIdle;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            remaining_q <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef RFG_AXIS_PROTOCOL_MASTER_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            remaining_q <= remaining_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef RFG_AXIS_PROTOCOL_MASTER_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

endmodule
